// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: transmit FIFO draining bytes to the board UART over the shared ram1 data bus
module uart_tx_buffer #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int WRN_LOW_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [7:0]        push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [7:0]        uart_data,
  output logic              uart_data_oe,
  output logic              wrn,
  input  logic              tbre,
  input  logic              tsre
);
  localparam int CW = WRN_LOW_CYCLES > 1 ? $clog2(WRN_LOW_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, REQ, SETUP, STROBE, RELEASE, GAP, WAIT_TBRE, WAIT_TSRE} state_t;
  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]       low_cnt;
  logic                pop, wr_en;
  assign pop   = state == RELEASE;
  assign wr_en = push && (!full || pop);
  assign full  = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign busy  = !empty || state != IDLE;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop) count <= count + 1'b1;
      else if (pop && !wr_en) count <= count - 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
    end
  // Outputs are registered alongside the state so they change on the same edge as the transition.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      bus_req      <= 1'b0;
      uart_data    <= '0;
      uart_data_oe <= 1'b0;
      wrn          <= 1'b1;
      low_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          state   <= REQ;
          bus_req <= 1'b1;
        end
        REQ: if (bus_gnt) begin
          state        <= SETUP;
          uart_data    <= mem[rd_ptr];
          uart_data_oe <= 1'b1;
        end
        SETUP: begin
          state   <= STROBE;
          wrn     <= 1'b0;
          low_cnt <= CW'(WRN_LOW_CYCLES - 1);
        end
        STROBE:
          if (low_cnt == '0) begin
            state <= RELEASE;
            wrn   <= 1'b1;
          end else low_cnt <= low_cnt - 1'b1;
        RELEASE: begin
          state        <= GAP;
          bus_req      <= 1'b0;
          uart_data_oe <= 1'b0;
        end
        GAP:       state <= WAIT_TBRE;
        WAIT_TBRE: if (tbre) state <= WAIT_TSRE;
        WAIT_TSRE: if (tsre) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed checks of the UART transmit buffer handshake and FIFO behaviour
module tb_uart_tx_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = '0;
  logic       full, empty, overflow, busy, bus_req, uart_data_oe, wrn;
  logic [4:0] count;
  logic       bus_gnt = 1'b0;
  logic [7:0] uart_data;
  logic       tbre = 1'b1;
  logic       tsre = 1'b1;
  int         vectors = 0;
  int         miscompares = 0;

  uart_tx_buffer dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .busy(busy), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .uart_data(uart_data), .uart_data_oe(uart_data_oe), .wrn(wrn), .tbre(tbre), .tsre(tsre)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    step();
    push = 1'b0;
  endtask

  // Returns the byte on the bus during a wrn pulse, leaving the bench in the RELEASE cycle.
  task automatic next_byte(input string tag, input logic [7:0] exp);
    bit seen = 0;
    bit rose = 0;
    logic [7:0] d = '0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      if (wrn === 1'b0) begin
        seen = 1;
        d = uart_data;
      end
    end
    for (int k = 0; k < 10 && seen && !rose; k++) begin
      step();
      if (wrn === 1'b1) rose = 1;
    end
    check({tag, "_strobe_seen"}, {31'd0, seen && rose}, 32'd1);
    check(tag, {24'd0, d}, {24'd0, exp});
  endtask

  initial begin
    bit bad;
    step(2);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_uart_data", uart_data, 0);
    check("rst_oe", uart_data_oe, 0);
    check("rst_wrn", wrn, 1);
    rst = 1'b0;
    bus_gnt = 1'b1;
    // single byte latency
    push_byte(8'h41);
    check("e0_count", count, 1);
    check("e0_bus_req", bus_req, 0);
    step();
    check("e1_bus_req", bus_req, 1);
    check("e1_oe", uart_data_oe, 0);
    step();
    check("e2_oe", uart_data_oe, 1);
    check("e2_data", uart_data, 8'h41);
    check("e2_wrn", wrn, 1);
    step();
    check("e3_wrn", wrn, 0);
    step();
    check("e4_wrn", wrn, 0);
    step();
    check("e5_wrn", wrn, 1);
    check("e5_oe", uart_data_oe, 1);
    step();
    check("e6_oe", uart_data_oe, 0);
    check("e6_bus_req", bus_req, 0);
    check("e6_empty", empty, 1);
    step(2);
    check("e8_busy", busy, 1);
    step();
    check("e9_busy", busy, 0);
    // async reset while wrn is low
    push_byte(8'h33);
    step(3);
    check("mid_wrn_low", wrn, 0);
    rst = 1'b1;
    #1;
    check("arst_wrn", wrn, 1);
    check("arst_oe", uart_data_oe, 0);
    check("arst_bus_req", bus_req, 0);
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    step();
    rst = 1'b0;
    // fill, overflow, drain in order
    bus_gnt = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_overflow", overflow, 0);
    push_byte(8'hAA);
    check("ovf_overflow", overflow, 1);
    check("ovf_count", count, 16);
    bus_gnt = 1'b1;
    for (int i = 0; i < 16; i++) next_byte($sformatf("drain_%0d", i), 8'(i));
    bad = 1;
    for (int k = 0; k < 20 && bad; k++) begin
      step();
      if (busy === 1'b0) bad = 0;
    end
    check("drain_idle", busy, 0);
    check("drain_empty", empty, 1);
    check("drain_overflow_sticky", overflow, 1);
    // push during RELEASE while full
    do_reset();
    bus_gnt = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    bus_gnt = 1'b1;
    next_byte("rel_first", 8'h00);
    check("rel_full_before", full, 1);
    push_byte(8'h55);
    check("rel_count", count, 16);
    check("rel_overflow", overflow, 0);
    for (int i = 1; i < 16; i++) next_byte($sformatf("rel_drain_%0d", i), 8'(i));
    next_byte("rel_last", 8'h55);
    // tbre / tsre waiting
    do_reset();
    tbre = 1'b0;
    tsre = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    next_byte("tbre_first", 8'h11);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (wrn !== 1'b1 || bus_req !== 1'b0) bad = 1;
    end
    check("tbre_hold_no_pulse", bad, 0);
    check("tbre_hold_count", count, 1);
    tbre = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (wrn !== 1'b1 || bus_req !== 1'b0) bad = 1;
    end
    check("tsre_hold_no_pulse", bad, 0);
    tsre = 1'b1;
    next_byte("tsre_second", 8'h22);
    // grant withheld
    do_reset();
    bus_gnt = 1'b0;
    push_byte(8'h77);
    step();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus_req !== 1'b1 || uart_data_oe !== 1'b0 || wrn !== 1'b1) bad = 1;
      step();
    end
    check("nognt_hold", bad, 0);
    bus_gnt = 1'b1;
    step();
    check("gnt_oe", uart_data_oe, 1);
    check("gnt_data", uart_data, 8'h77);
    check("gnt_wrn", wrn, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
